// File: rtl/an_code_pkg.sv
// Shared types and sizing helpers for the AN-code single-error-correcting decoder.
// Width helpers let any odd check constant A and data width K size the datapath.
package an_code_pkg;

    localparam int DEF_A = 13837;
    localparam int DEF_K = 24;

    typedef enum logic [2:0] {
        IDLE,
        DIV1,
        SEARCH,
        DIV2,
        DONE
    } state_e;

    function automatic int calc_rw(input int a);
        return $clog2(a);
    endfunction

    function automatic int calc_cw(input int k, input int a);
        return k + $clog2(a);
    endfunction

    function automatic int calc_pw(input int k, input int a);
        return $clog2(k + $clog2(a));
    endfunction

endpackage

// File: rtl/an_serial_divider.sv
// Bit-serial restoring divider, MSB first, one quotient bit per cycle.
// quotient_o/remainder_o show next-state values, so they are final in the done_o cycle.
module an_serial_divider
    import an_code_pkg::*;
#(
    parameter int CW = 38,
    parameter int RW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [CW-1:0] dividend_i,
    input  logic [RW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] quotient_o,
    output logic [RW-1:0] remainder_o
);
    localparam int CNTW = $clog2(CW + 1);

    logic [RW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   quo_q, quo_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [RW:0]     trial;
    logic [RW-1:0]   diff;
    logic            ge;

    always_comb begin
        trial  = {rem_q, quo_q[CW-1]};
        ge     = (trial >= {1'b0, divisor_i});
        // trial < 2*divisor, so the difference always fits RW bits
        diff   = trial[RW-1:0] - divisor_i;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            cnt_d  = CNTW'(CW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? diff : trial[RW-1:0];
            quo_d  = {quo_q[CW-2:0], ge};
            cnt_d  = cnt_q - CNTW'(1);
            busy_d = (cnt_q != CNTW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == CNTW'(1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/an_sec_decoder_seq.sv
// Sequential AN-code decoder: divide, search residues +-2^i, correct, divide again.
// One word in flight; a single shared serial divider serves both division passes.
module an_sec_decoder_seq
    import an_code_pkg::*;
#(
    parameter int K  = DEF_K,
    parameter int A  = DEF_A,
    parameter int RW = calc_rw(A),
    parameter int CW = calc_cw(K, A),
    parameter int PW = calc_pw(K, A)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_n,
    output logic          out_corrected,
    output logic          out_uncorrectable,
    output logic [PW-1:0] out_err_pos,
    output logic          out_err_neg
);
    localparam int            CW1  = CW + 1;
    localparam logic [RW-1:0] A_RW = RW'(A);

    state_e        state_q, state_d;
    logic [CW-1:0] w_q, w_d;
    logic [K-1:0]  qlo_q, qlo_d;
    logic [RW-1:0] r1_q, r1_d;
    logic [RW-1:0] p_q, p_d;
    logic [PW-1:0] i_q, i_d;
    logic          neg_q, neg_d;
    logic [K-1:0]  n_q, n_d;
    logic          corr_q, corr_d;
    logic          unc_q, unc_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          eneg_q, eneg_d;

    logic          div_start, div_busy, div_done;
    logic [CW-1:0] div_dividend, div_quo;
    logic [RW-1:0] div_rem;

    logic          hit_pos, hit_neg, div2_bad;
    logic [CW1-1:0] pow2, wc;
    logic          wc_oor;
    logic [RW:0]   p_dbl;
    logic [RW-1:0] p_next;

    // p tracks 2^i mod A, so R matches +2^i on p and -2^i on A-p
    assign hit_pos = (r1_q == p_q);
    assign hit_neg = (r1_q == A_RW - p_q);
    assign pow2    = CW1'(1) << i_q;
    assign wc      = hit_pos ? ({1'b0, w_q} - pow2) : ({1'b0, w_q} + pow2);
    assign wc_oor  = wc[CW];
    assign p_dbl   = {p_q, 1'b0};
    assign p_next  = (p_dbl >= {1'b0, A_RW}) ? (p_dbl[RW-1:0] - A_RW) : p_dbl[RW-1:0];

    // Kept apart from the FSM block: divider outputs depend combinationally on start
    assign div_start    = ((state_q == DIV1) && !div_busy) ||
                          ((state_q == SEARCH) && (hit_pos || hit_neg) && !wc_oor);
    assign div_dividend = (state_q == SEARCH) ? wc[CW-1:0] : w_q;
    assign div2_bad     = (div_rem != '0) || (|div_quo[CW-1:K]);

    an_serial_divider #(.CW(CW), .RW(RW)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .dividend_i  (div_dividend),
        .divisor_i   (A_RW),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        qlo_d   = qlo_q;
        r1_d    = r1_q;
        p_d     = p_q;
        i_d     = i_q;
        neg_d   = neg_q;
        n_d     = n_q;
        corr_d  = corr_q;
        unc_d   = unc_q;
        pos_d   = pos_q;
        eneg_d  = eneg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = in_w;
                    state_d = DIV1;
                end
            end
            DIV1: begin
                if (div_done) begin
                    qlo_d = div_quo[K-1:0];
                    r1_d  = div_rem;
                    p_d   = RW'(1);
                    i_d   = '0;
                    if (div_rem == '0) begin
                        n_d     = div_quo[K-1:0];
                        corr_d  = 1'b0;
                        unc_d   = |div_quo[CW-1:K];
                        pos_d   = '0;
                        eneg_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if ((hit_pos || hit_neg) && !wc_oor) begin
                    neg_d   = !hit_pos;
                    state_d = DIV2;
                end else if (hit_pos || hit_neg || (i_q == PW'(CW - 1))) begin
                    // no usable match: report first-pass quotient, no position
                    n_d     = qlo_q;
                    corr_d  = 1'b0;
                    unc_d   = 1'b1;
                    pos_d   = '0;
                    eneg_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    i_d = i_q + PW'(1);
                    p_d = p_next;
                end
            end
            DIV2: begin
                if (div_done) begin
                    n_d     = div_quo[K-1:0];
                    pos_d   = i_q;
                    eneg_d  = neg_q;
                    unc_d   = div2_bad;
                    corr_d  = !div2_bad;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            qlo_q   <= '0;
            r1_q    <= '0;
            p_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            n_q     <= '0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            pos_q   <= '0;
            eneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            qlo_q   <= qlo_d;
            r1_q    <= r1_d;
            p_q     <= p_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            n_q     <= n_d;
            corr_q  <= corr_d;
            unc_q   <= unc_d;
            pos_q   <= pos_d;
            eneg_q  <= eneg_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign out_n             = n_q;
    assign out_corrected     = corr_q;
    assign out_uncorrectable = unc_q;
    assign out_err_pos       = pos_q;
    assign out_err_neg       = eneg_q;

endmodule
